dm_pipe_ctrl: RTL and testbench
===============================

Name: dm_pipe_ctrl

Overview:
- Parametrised data-memory controller that replaces the single-cycle word memory and its separate store-format and load-extend helpers with one pipelined block.
- Accepts load/store requests on a valid/ready handshake and performs byte-lane store formatting internally.
- Reads the synchronous memory array with a configurable latency.
- Returns sign- or zero-extended load data in order, through a response FIFO, with misalignment error reporting.

Parameters:
- DATA_WIDTH, 32, word width; legal values 32 or 64. NB = DATA_WIDTH/8 byte lanes; OFF = log2(NB) address offset bits.
- DEPTH_LOG2, 10, log2 of array depth in words; the word index is addr[DEPTH_LOG2+OFF-1:OFF].
- RD_LAT, 1, cycles from request acceptance to earliest rsp_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_WIDTH=64).
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and for errored requests.
- rsp_err  out  1  misaligned or illegal-size request.

Behaviour:
- Reset (asynchronous, takes effect immediately, overrides everything including mid-flight requests):
  - Clears all pipeline valid bits, the FIFO pointers and the occupancy counter.
  - Outputs: rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 from the first edge after rst deasserts.
  - The memory array is not reset. In-flight responses are discarded.
- Acceptance: a request is accepted on a rising edge with req_valid & req_ready. A single request can be accepted per cycle.
- Byte lanes are little-endian: lane i = bits [8i+7:8i], and lane index = addr[OFF-1:0].
- Misaligned or illegal requests:
  - Misaligned means a half with addr[0]≠0, a word with addr[1:0]≠0, or a dword with addr[2:0]≠0.
  - Illegal means size 3 when DATA_WIDTH=32.
  - Effect: no array write, rsp_err=1, rsp_rdata=0. The request still occupies a response slot and keeps its place in order.
- Store:
  - Replicate the low 2^size bytes of req_wdata across the word.
  - Byte enable = a contiguous mask of 2^size lanes starting at the lane index.
  - The array write commits at the acceptance edge.
  - A store produces a response with rsp_err as computed and rsp_rdata=0.
- Load:
  - The array is read synchronously at the acceptance edge, so a same-edge store to the same word is not visible; a store accepted on any earlier edge is visible.
  - The raw word then passes through RD_LAT-1 further register stages.
  - Extraction: take the 2^size bytes at the lane index, then zero- or sign-extend them to DATA_WIDTH per req_signed.
- Pipeline and FIFO:
  - Each stage carries {valid, wr, size, signed, lane, err, data}.
  - Stage RD_LAT writes into an in-order response FIFO of depth RD_LAT+1.
  - FIFO head drives rsp_valid, rsp_rdata and rsp_err (fall-through: a response can appear in cycle accept+RD_LAT).
  - Pipeline stages never stall; flow control is credit-based.
- Credit counter cnt (0..RD_LAT+1):
  - +1 on accept, −1 on rsp_valid & rsp_ready; both events in one cycle leave cnt unchanged.
  - req_ready = (cnt < RD_LAT+1) | (rsp_valid & rsp_ready), so the FIFO can never overflow.
- Throughput: 1 request/cycle sustained while rsp_ready is held at 1.
- Response ordering: responses leave in acceptance order, including error responses.
- Response hold: rsp_rdata and rsp_err are held stable while rsp_valid=1 & rsp_ready=0.

Test Plan:
- DATA_WIDTH=32, RD_LAT=1: store word 0x11223344 @0x10 (cycle 0), load word @0x10 (cycle 1) -> rsp for the load in cycle 2 with rsp_rdata=0x11223344, err=0.
- Store byte 0xA5 @0x13, then load-byte signed @0x13 -> rsp_rdata=0xFFFFFFA5. Load-half unsigned @0x12 -> 0x0000A522. Load word @0x10 -> 0xA5223344.
- Load half @0x11 -> rsp_err=1, rsp_rdata=0, memory unchanged. Size 3 with DATA_WIDTH=32 -> rsp_err=1.
- RD_LAT=3, rsp_ready=0, req_valid held high -> exactly 4 accepts, then req_ready=0. Raise rsp_ready -> 4 responses in order with no loss, and req_ready returns to 1.
- DATA_WIDTH=64: store dword 0x0123456789ABCDEF @0x8; load-word signed @0xC -> 0x0000000001234567; load-byte signed @0x8 -> 0xFFFFFFFFFFFFFFEF.
- Assert rst while 2 loads are in flight -> rsp_valid=0 immediately and req_ready=1 after release. Array contents written before reset remain readable.

Source files
------------

// File: rtl/dm_pipe_ctrl.sv
// Pipelined data-memory controller: byte-lane stores, synchronous loads with
// RD_LAT read stages, sign/zero extension and an in-order credit-managed response FIFO.
module dm_pipe_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FD    = RD_LAT + 1;
    localparam int PW    = $clog2(FD);
    localparam int FS    = 1 << PW;
    localparam int CW    = $clog2(FD + 1);

    function automatic logic bad_req_f(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr[0];
            2'd2:    bad = (addr[1:0] != 2'b00);
            default: bad = (DATA_WIDTH == 32) ? 1'b1 : (addr[2:0] != 3'b000);
        endcase
        return bad;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] st_data_f(input logic [1:0] size,
                                                        input logic [DATA_WIDTH-1:0] wd);
        logic [DATA_WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < NB; i++) begin
            case (size)
                2'd0:    res[8*i +: 8] = wd[7:0];
                2'd1:    res[8*i +: 8] = wd[8*(i%2) +: 8];
                2'd2:    res[8*i +: 8] = wd[8*(i%4) +: 8];
                default: res[8*i +: 8] = wd[8*i +: 8];
            endcase
        end
        return res;
    endfunction

    function automatic logic [NB-1:0] st_be_f(input logic [1:0] size, input logic [OFF-1:0] lane);
        logic [NB-1:0] be;
        int lo;
        int n;
        lo = int'(lane);
        n  = int'(32'd1 << size);
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= lo) && (i < lo + n);
        end
        return be;
    endfunction

    // The sign bit is picked up while walking upward, so the bits above it can reuse it.
    function automatic logic [DATA_WIDTH-1:0] ld_ext_f(input logic [DATA_WIDTH-1:0] word,
                                                       input logic [1:0] size,
                                                       input logic [OFF-1:0] lane,
                                                       input logic sgn);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] res;
        logic sb;
        int nbits;
        sh    = word >> {lane, 3'b000};
        nbits = (int'(32'd8 << size) > DATA_WIDTH) ? DATA_WIDTH : int'(32'd8 << size);
        sb    = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            sb     = (i == nbits - 1) ? (sgn & sh[i]) : sb;
            res[i] = (i < nbits) ? sh[i] : sb;
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] nxt_ptr_f(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    logic                  accept_s;
    logic                  req_ready_s;
    logic                  err_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic [OFF-1:0]        lane_s;
    logic [DATA_WIDTH-1:0] wfmt_s;
    logic [NB-1:0]         be_s;
    logic                  unused_addr_s;

    logic [RD_LAT:1]       stg_v_r;
    logic [RD_LAT:1]       stg_wr_r;
    logic [RD_LAT:1]       stg_sg_r;
    logic [RD_LAT:1]       stg_err_r;
    logic [1:0]            stg_sz_r [1:RD_LAT];
    logic [OFF-1:0]        stg_ln_r [1:RD_LAT];
    logic [DATA_WIDTH-1:0] stg_d_r  [1:RD_LAT];
    logic [DATA_WIDTH-1:0] stg_rd_s;

    logic [DATA_WIDTH-1:0] fq_d_r [0:FS-1];
    logic [FS-1:0]         fq_e_r;
    logic [PW-1:0]         wp_r;
    logic [PW-1:0]         rp_r;
    logic [CW-1:0]         fcnt_r;
    logic [CW-1:0]         cnt_r;

    logic                  rsp_valid_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_s;
    logic                  rsp_err_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  fifo_pop_s;

    assign idx_s         = req_addr[DEPTH_LOG2+OFF-1:OFF];
    assign lane_s        = req_addr[OFF-1:0];
    assign err_s         = bad_req_f(req_size, req_addr);
    assign wfmt_s        = st_data_f(req_size, req_wdata);
    assign be_s          = st_be_f(req_size, lane_s);
    assign unused_addr_s = ^req_addr;

    // A pop in the same cycle frees the credit that a new request consumes.
    assign pop_s       = rsp_valid_s & rsp_ready;
    assign req_ready_s = ~rst & ((cnt_r < CW'(FD)) | pop_s);
    assign accept_s    = req_valid & req_ready_s;

    // Byte-masked array write at the acceptance edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (accept_s & req_wr & ~err_s) begin
            for (int i = 0; i < NB; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wfmt_s[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 1 samples the pre-write word, later stages only shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_v_r   <= '0;
            stg_wr_r  <= '0;
            stg_sg_r  <= '0;
            stg_err_r <= '0;
            for (int k = 1; k <= RD_LAT; k++) begin
                stg_sz_r[k] <= 2'd0;
                stg_ln_r[k] <= '0;
                stg_d_r[k]  <= '0;
            end
        end else begin
            stg_v_r[1]   <= accept_s;
            stg_wr_r[1]  <= req_wr;
            stg_sg_r[1]  <= req_signed;
            stg_err_r[1] <= err_s;
            stg_sz_r[1]  <= req_size;
            stg_ln_r[1]  <= lane_s;
            stg_d_r[1]   <= mem_r[idx_s];
            for (int k = 2; k <= RD_LAT; k++) begin
                stg_v_r[k]   <= stg_v_r[k-1];
                stg_wr_r[k]  <= stg_wr_r[k-1];
                stg_sg_r[k]  <= stg_sg_r[k-1];
                stg_err_r[k] <= stg_err_r[k-1];
                stg_sz_r[k]  <= stg_sz_r[k-1];
                stg_ln_r[k]  <= stg_ln_r[k-1];
                stg_d_r[k]   <= stg_d_r[k-1];
            end
        end
    end

    assign stg_rd_s = (stg_wr_r[RD_LAT] | stg_err_r[RD_LAT]) ? '0 :
                      ld_ext_f(stg_d_r[RD_LAT], stg_sz_r[RD_LAT], stg_ln_r[RD_LAT], stg_sg_r[RD_LAT]);

    // An empty FIFO with a ready consumer lets the last stage bypass storage.
    assign push_s     = stg_v_r[RD_LAT] & ~((fcnt_r == '0) & rsp_ready);
    assign fifo_pop_s = pop_s & (fcnt_r != '0);

    // Response FIFO pointers, occupancy and the request credit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r   <= '0;
            rp_r   <= '0;
            fcnt_r <= '0;
            cnt_r  <= '0;
            fq_e_r <= '0;
            for (int k = 0; k < FS; k++) begin
                fq_d_r[k] <= '0;
            end
        end else begin
            if (push_s) begin
                fq_d_r[wp_r] <= stg_rd_s;
                fq_e_r[wp_r] <= stg_err_r[RD_LAT];
                wp_r         <= nxt_ptr_f(wp_r);
            end
            if (fifo_pop_s) begin
                rp_r <= nxt_ptr_f(rp_r);
            end
            fcnt_r <= fcnt_r + CW'(push_s) - CW'(fifo_pop_s);
            cnt_r  <= cnt_r + CW'(accept_s) - CW'(pop_s);
        end
    end

    // Head selection: stored entries first, otherwise the final pipeline stage.
    always_comb begin
        rsp_valid_s = 1'b0;
        rsp_rdata_s = '0;
        rsp_err_s   = 1'b0;
        if (fcnt_r != '0) begin
            rsp_valid_s = 1'b1;
            rsp_rdata_s = fq_d_r[rp_r];
            rsp_err_s   = fq_e_r[rp_r];
        end else if (stg_v_r[RD_LAT]) begin
            rsp_valid_s = 1'b1;
            rsp_rdata_s = stg_rd_s;
            rsp_err_s   = stg_err_r[RD_LAT];
        end else begin
            rsp_valid_s = 1'b0;
            rsp_rdata_s = '0;
            rsp_err_s   = 1'b0;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_s;
    assign rsp_rdata = rsp_rdata_s;
    assign rsp_err   = rsp_err_s;

endmodule

// File: tb/tb_dm_pipe_ctrl.sv
// Self-checking bench: a 32-bit RD_LAT=1 instance and a 64-bit RD_LAT=3 instance,
// each with an expected-response queue popped as responses are consumed.
module tb_dm_pipe_ctrl;
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [63:0] d;
        logic        e;
    } exp_t;

    logic clk;
    logic rst;

    logic        a_req_valid, a_req_ready, a_req_wr, a_req_signed;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;

    logic        b_req_valid, b_req_ready, b_req_wr, b_req_signed;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;

    int n_pass  = 0;
    int n_total = 0;

    exp_t a_q[$];
    exp_t b_q[$];

    logic        a_hold_v;
    logic [32:0] a_hold;

    dm_pipe_ctrl #(.DATA_WIDTH(32), .DEPTH_LOG2(8), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
        .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dm_pipe_ctrl #(.DATA_WIDTH(64), .DEPTH_LOG2(8), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [63:0] exp, input logic err);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.exp = exp; v.err = err;
        return v;
    endfunction

    // Scoreboard for instance A, plus stability of a stalled response.
    always @(negedge clk) begin
        if (a_rsp_valid && a_rsp_ready) begin
            if (a_q.size() == 0) begin
                n_total++;
                $display("FAIL a_unexpected_rsp: got rdata 0x%0h with nothing outstanding", a_rsp_rdata);
            end else begin
                chk("a_rdata", {32'd0, a_rsp_rdata}, a_q[0].d);
                chk("a_err", {63'd0, a_rsp_err}, {63'd0, a_q[0].e});
                void'(a_q.pop_front());
            end
        end
        if (a_hold_v && a_rsp_valid) begin
            chk("a_hold", {31'd0, a_rsp_err, a_rsp_rdata}, {31'd0, a_hold});
        end
        a_hold_v <= a_rsp_valid && !a_rsp_ready && !rst;
        a_hold   <= {a_rsp_err, a_rsp_rdata};
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (b_rsp_valid && b_rsp_ready) begin
            if (b_q.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected_rsp: got rdata 0x%0h with nothing outstanding", b_rsp_rdata);
            end else begin
                chk("b_rdata", b_rsp_rdata, b_q[0].d);
                chk("b_err", {63'd0, b_rsp_err}, {63'd0, b_q[0].e});
                void'(b_q.pop_front());
            end
        end
    end

    task automatic send_a(input vec_t v, input bit rnd);
        bit ok;
        ok = 1'b0;
        a_req_valid  = 1'b1;
        a_req_wr     = v.wr;
        a_req_size   = v.size;
        a_req_signed = v.sgn;
        a_req_addr   = v.addr;
        a_req_wdata  = v.wdata[31:0];
        for (int i = 0; i < 64; i++) begin
            if (rnd) a_rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (a_req_ready) begin
                ok = 1'b1;
                a_q.push_back({v.exp, v.err});
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("a_accept_timeout", {63'd0, ok}, 64'd1);
        a_req_valid = 1'b0;
    endtask

    task automatic send_b(input vec_t v);
        bit ok;
        ok = 1'b0;
        b_req_valid  = 1'b1;
        b_req_wr     = v.wr;
        b_req_size   = v.size;
        b_req_signed = v.sgn;
        b_req_addr   = v.addr;
        b_req_wdata  = v.wdata;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (b_req_ready) begin
                ok = 1'b1;
                b_q.push_back({v.exp, v.err});
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("b_accept_timeout", {63'd0, ok}, 64'd1);
        b_req_valid = 1'b0;
    endtask

    task automatic drain_a();
        bit ok;
        ok = 1'b0;
        a_rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (a_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        chk("a_drain_done", {63'd0, ok}, 64'd1);
        chk("a_drain_idle", {63'd0, a_rsp_valid}, 64'd0);
    endtask

    task automatic drain_b();
        bit ok;
        ok = 1'b0;
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (b_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        chk("b_drain_done", {63'd0, ok}, 64'd1);
        chk("b_drain_idle", {63'd0, b_rsp_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[19];
        vec_t bp[5];
        int   k;
        int   idx;

        tbl[0]  = mk(1'b1, 2'd2, 1'b0, 32'h10, 64'h11223344, 64'h0,        1'b0);
        tbl[1]  = mk(1'b0, 2'd2, 1'b0, 32'h10, 64'h0,        64'h11223344, 1'b0);
        tbl[2]  = mk(1'b1, 2'd0, 1'b0, 32'h13, 64'hA5,       64'h0,        1'b0);
        tbl[3]  = mk(1'b0, 2'd0, 1'b1, 32'h13, 64'h0,        64'hFFFFFFA5, 1'b0);
        tbl[4]  = mk(1'b0, 2'd1, 1'b0, 32'h12, 64'h0,        64'h0000A522, 1'b0);
        tbl[5]  = mk(1'b0, 2'd2, 1'b0, 32'h10, 64'h0,        64'hA5223344, 1'b0);
        tbl[6]  = mk(1'b0, 2'd1, 1'b0, 32'h11, 64'h0,        64'h0,        1'b1);
        tbl[7]  = mk(1'b0, 2'd3, 1'b0, 32'h10, 64'h0,        64'h0,        1'b1);
        tbl[8]  = mk(1'b1, 2'd1, 1'b0, 32'h11, 64'hBEEF,     64'h0,        1'b1);
        tbl[9]  = mk(1'b0, 2'd2, 1'b0, 32'h10, 64'h0,        64'hA5223344, 1'b0);
        tbl[10] = mk(1'b1, 2'd1, 1'b0, 32'h16, 64'h8001,     64'h0,        1'b0);
        tbl[11] = mk(1'b0, 2'd1, 1'b1, 32'h16, 64'h0,        64'hFFFF8001, 1'b0);
        tbl[12] = mk(1'b0, 2'd0, 1'b0, 32'h17, 64'h0,        64'h00000080, 1'b0);
        tbl[13] = mk(1'b1, 2'd3, 1'b0, 32'h18, 64'h12345678, 64'h0,        1'b1);
        tbl[14] = mk(1'b1, 2'd0, 1'b0, 32'h14, 64'h7F,       64'h0,        1'b0);
        tbl[15] = mk(1'b0, 2'd0, 1'b1, 32'h14, 64'h0,        64'h0000007F, 1'b0);
        tbl[16] = mk(1'b1, 2'd2, 1'b0, 32'h20, 64'hCAFEF00D, 64'h0,        1'b0);
        tbl[17] = mk(1'b0, 2'd1, 1'b1, 32'h22, 64'h0,        64'hFFFFCAFE, 1'b0);
        tbl[18] = mk(1'b0, 2'd0, 1'b0, 32'h20, 64'h0,        64'h0000000D, 1'b0);

        bp[0] = mk(1'b0, 2'd3, 1'b0, 32'h8, 64'h0, 64'h0123456789ABCDEF, 1'b0);
        bp[1] = mk(1'b0, 2'd1, 1'b0, 32'hA, 64'h0, 64'h00000000000089AB, 1'b0);
        bp[2] = mk(1'b0, 2'd0, 1'b0, 32'hF, 64'h0, 64'h0000000000000001, 1'b0);
        bp[3] = mk(1'b0, 2'd1, 1'b1, 32'hA, 64'h0, 64'hFFFFFFFFFFFF89AB, 1'b0);
        bp[4] = mk(1'b0, 2'd0, 1'b1, 32'hE, 64'h0, 64'h0000000000000023, 1'b0);

        rst = 1'b1;
        a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_size = 2'd0; a_req_signed = 1'b0;
        a_req_addr = 32'd0; a_req_wdata = 32'd0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_size = 2'd0; b_req_signed = 1'b0;
        b_req_addr = 32'd0; b_req_wdata = 64'd0; b_rsp_ready = 1'b1;

        #13;
        chk("rst_a_rsp_valid", {63'd0, a_rsp_valid}, 64'd0);
        chk("rst_a_rsp_rdata", {32'd0, a_rsp_rdata}, 64'd0);
        chk("rst_a_rsp_err", {63'd0, a_rsp_err}, 64'd0);
        chk("rst_b_rsp_valid", {63'd0, b_rsp_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_a_ready", {63'd0, a_req_ready}, 64'd1);
        chk("post_rst_b_ready", {63'd0, b_req_ready}, 64'd1);

        // Back-to-back table, consumer always ready.
        for (int i = 0; i < 19; i++) send_a(tbl[i], 1'b0);
        drain_a();

        // Same table with a randomly stalling consumer.
        for (int i = 0; i < 19; i++) send_a(tbl[i], 1'b1);
        drain_a();

        // Fall-through latency: response visible one cycle after acceptance.
        send_a(tbl[5], 1'b0);
        chk("a_lat1_valid", {63'd0, a_rsp_valid}, 64'd1);
        chk("a_lat1_rdata", {32'd0, a_rsp_rdata}, 64'hA5223344);
        drain_a();

        // 64-bit instance: dword store and extracting loads.
        send_b(mk(1'b1, 2'd3, 1'b0, 32'h8, 64'h0123456789ABCDEF, 64'h0, 1'b0));
        send_b(mk(1'b0, 2'd2, 1'b1, 32'hC, 64'h0, 64'h0000000001234567, 1'b0));
        send_b(mk(1'b0, 2'd0, 1'b1, 32'h8, 64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0));
        send_b(mk(1'b0, 2'd2, 1'b1, 32'h8, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0));
        send_b(mk(1'b0, 2'd3, 1'b0, 32'hC, 64'h0, 64'h0, 1'b1));
        drain_b();

        // Credit limit: consumer stalled, request held high.
        b_rsp_ready = 1'b0;
        b_req_valid = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            idx = (k < 5) ? k : 4;
            b_req_wr = bp[idx].wr; b_req_size = bp[idx].size; b_req_signed = bp[idx].sgn;
            b_req_addr = bp[idx].addr; b_req_wdata = bp[idx].wdata;
            @(negedge clk);
            if (b_req_ready) begin
                b_q.push_back({bp[idx].exp, bp[idx].err});
                k++;
            end
            @(posedge clk);
            #1;
        end
        chk("b_credit_accepts", 64'(k), 64'd4);
        chk("b_credit_ready_low", {63'd0, b_req_ready}, 64'd0);
        b_req_valid = 1'b0;
        drain_b();
        chk("b_credit_ready_back", {63'd0, b_req_ready}, 64'd1);

        // Reset with two loads outstanding.
        a_rsp_ready = 1'b0;
        send_a(tbl[5], 1'b0);
        send_a(tbl[11], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_rsp_valid", {63'd0, a_rsp_valid}, 64'd0);
        a_q.delete();
        b_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_ready", {63'd0, a_req_ready}, 64'd1);
        chk("rst_mid_idle", {63'd0, a_rsp_valid}, 64'd0);
        send_a(tbl[5], 1'b0);
        send_a(tbl[11], 1'b0);
        drain_a();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
